// File: rtl/wave_synth_pkg.sv
// Shared types and default parameters for the wave_synth DDS block.
package wave_synth_pkg;

    localparam int DEF_PHASE_W = 32;
    localparam int DEF_LUT_AW  = 10;
    localparam int DEF_OUT_W   = 16;

    typedef enum logic [1:0] {
        SINE     = 2'd0,
        SQUARE   = 2'd1,
        SAW      = 2'd2,
        TRIANGLE = 2'd3
    } wave_mode_t;

    typedef struct packed {
        logic [15:0] amp;
        wave_mode_t  mode;
        logic        enable;
        logic        phase_rst;
    } cfg_ctrl_t;

endpackage

// File: rtl/wave_sine_rom.sv
// Quarter-wave sine table with a registered read; contents are built at elaboration.
module wave_sine_rom #(
    parameter int LUT_AW = 10,
    parameter int OUT_W  = 16
) (
    input  logic              clk,
    input  logic [LUT_AW-1:0] addr,
    output logic [OUT_W-2:0]  data
);

    localparam int  N       = 1 << LUT_AW;
    localparam real MAX_R   = real'((2 ** (OUT_W - 1)) - 1);
    localparam real PI_HALF = 1.5707963267948966;

    // Taylor series keeps table generation free of tool-specific math builtins.
    function automatic real sin_r(input real x);
        real term;
        real sum;
        term = x;
        sum  = x;
        for (int unsigned n = 1; n < 14; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

    logic [OUT_W-2:0] lut [N];

    for (genvar i = 0; i < N; i++) begin : g_lut
        localparam int VAL = $rtoi(MAX_R * sin_r(PI_HALF * real'(i) / real'(N)) + 0.5);
        assign lut[i] = VAL[OUT_W-2:0];
    end

    always_ff @(posedge clk) begin
        data <= lut[addr];
    end

endmodule

// File: rtl/wave_synth.sv
// Phase-accumulator waveform synthesiser with shadowed config and a 3-stage output pipeline.
module wave_synth
    import wave_synth_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int LUT_AW  = DEF_LUT_AW,
    parameter int OUT_W   = DEF_OUT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sample_en,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [PHASE_W-1:0]      cfg_inc,
    input  logic [PHASE_W-1:0]      cfg_offset,
    input  logic [15:0]             cfg_amp,
    input  logic [1:0]              cfg_mode,
    input  logic                    cfg_enable,
    input  logic                    cfg_phase_rst,
    output logic signed [OUT_W-1:0] wave_out,
    output logic                    out_valid
);

    localparam int TOP_W = (OUT_W + 1 > LUT_AW + 2) ? OUT_W + 1 : LUT_AW + 2;
    localparam int PW    = OUT_W + 17;
    localparam logic signed [OUT_W-1:0] WMAX   = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [PW-1:0]    SAT_HI = {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [PW-1:0]    SAT_LO = {{(PW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    cfg_ctrl_t          sh_ctrl;
    logic [PHASE_W-1:0] sh_inc, sh_off;
    logic [PHASE_W-1:0] act_inc, act_off, acc;
    logic [15:0]        act_amp;
    wave_mode_t         act_mode;
    logic               act_en, pending;

    logic               commit, sample, eff_en;
    logic [PHASE_W-1:0] eff_inc, eff_off, base, phase;
    logic [15:0]        eff_amp;
    wave_mode_t         eff_mode;

    logic               v1, v2;
    logic [TOP_W-1:0]   p1;
    logic [OUT_W:0]     p2;
    wave_mode_t         mode1, mode2;
    logic [15:0]        amp1, amp2;
    logic [1:0]         q1;
    logic [LUT_AW-1:0]  k1, rom_addr;
    logic [OUT_W-2:0]   rom_data;

    logic signed [OUT_W-1:0] wave, sat;
    logic [OUT_W-1:0]        tri_u;
    logic signed [PW-1:0]    wave_x, amp_x, prod, scaled;

    // A commit and a sample can coincide; the sample then sees the new settings.
    always_comb begin
        commit   = pending && (sample_en || !act_en);
        eff_inc  = commit ? sh_inc            : act_inc;
        eff_off  = commit ? sh_off            : act_off;
        eff_amp  = commit ? sh_ctrl.amp       : act_amp;
        eff_mode = commit ? sh_ctrl.mode      : act_mode;
        eff_en   = commit ? sh_ctrl.enable    : act_en;
        base     = (commit && sh_ctrl.phase_rst) ? '0 : acc;
        sample   = sample_en && eff_en;
        phase    = base + eff_off;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_ctrl   <= '{amp: '0, mode: SINE, enable: 1'b0, phase_rst: 1'b0};
            sh_inc    <= '0;
            sh_off    <= '0;
            act_inc   <= '0;
            act_off   <= '0;
            act_amp   <= '0;
            act_mode  <= SINE;
            act_en    <= 1'b0;
            acc       <= '0;
            pending   <= 1'b0;
            cfg_ready <= 1'b1;
            v1        <= 1'b0;
            v2        <= 1'b0;
            p1        <= '0;
            p2        <= '0;
            mode1     <= SINE;
            mode2     <= SINE;
            amp1      <= '0;
            amp2      <= '0;
            wave_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (cfg_valid && cfg_ready) begin
                sh_ctrl   <= '{amp: cfg_amp, mode: wave_mode_t'(cfg_mode),
                               enable: cfg_enable, phase_rst: cfg_phase_rst};
                sh_inc    <= cfg_inc;
                sh_off    <= cfg_offset;
                pending   <= 1'b1;
                cfg_ready <= 1'b0;
            end
            if (commit) begin
                act_inc   <= sh_inc;
                act_off   <= sh_off;
                act_amp   <= sh_ctrl.amp;
                act_mode  <= sh_ctrl.mode;
                act_en    <= sh_ctrl.enable;
                pending   <= 1'b0;
                cfg_ready <= 1'b1;
            end
            if (sample)
                acc <= base + eff_inc;
            else if (commit && sh_ctrl.phase_rst)
                acc <= '0;

            v1 <= sample;
            if (sample) begin
                p1    <= phase[PHASE_W-1 -: TOP_W];
                mode1 <= eff_mode;
                amp1  <= eff_amp;
            end
            v2 <= v1;
            if (v1) begin
                p2    <= p1[TOP_W-1 -: OUT_W+1];
                mode2 <= mode1;
                amp2  <= amp1;
            end
            out_valid <= v2;
            if (v2)
                wave_out <= sat;
        end
    end

    assign q1       = p1[TOP_W-1 -: 2];
    assign k1       = p1[TOP_W-3 -: LUT_AW];
    assign rom_addr = q1[0] ? ~k1 : k1;

    wave_sine_rom #(.LUT_AW(LUT_AW), .OUT_W(OUT_W)) u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    // p2[OUT_W] is the phase MSB, i.e. the lower/upper half-cycle flag.
    always_comb begin
        tri_u = p2[OUT_W] ? ~p2[OUT_W-1:0] : p2[OUT_W-1:0];
        case (mode2)
            SINE:     wave = p2[OUT_W] ? -$signed({1'b0, rom_data}) : $signed({1'b0, rom_data});
            SQUARE:   wave = p2[OUT_W] ? -WMAX : WMAX;
            SAW:      wave = $signed({~p2[OUT_W], p2[OUT_W-1:1]});
            default:  wave = $signed({~tri_u[OUT_W-1], tri_u[OUT_W-2:0]});
        endcase
        wave_x = PW'(wave);
        amp_x  = PW'($signed({1'b0, amp2}));
        prod   = wave_x * amp_x;
        scaled = prod >>> 15;
        if (scaled > SAT_HI)
            sat = WMAX;
        else if (scaled < SAT_LO)
            sat = -WMAX - 1'b1;
        else
            sat = scaled[OUT_W-1:0];
    end

endmodule

// File: doc/wave_synth.md
WAVE_SYNTH -- requirements
Module: wave_synth

Interface
REQ-001 SHALL have parameter PHASE_W, default 32, phase accumulator width.
REQ-002 SHALL have parameter LUT_AW, default 10, quarter-wave table address width (2^LUT_AW entries).
REQ-003 SHALL have parameter OUT_W, default 16, signed sample width; MAX = 2^(OUT_W-1)-1.
REQ-004 SHALL have ports: clk in 1 clock; rst_n in 1 reset. One clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports: sample_en in 1 sample tick; cfg_valid in 1; cfg_ready out 1; cfg_inc in PHASE_W phase step; cfg_offset in PHASE_W phase offset; cfg_amp in 16 unsigned gain, 0x8000 = unity; cfg_mode in 2 waveform; cfg_enable in 1; cfg_phase_rst in 1 zero accumulator on commit.
REQ-006 SHALL have ports: wave_out out OUT_W signed sample; out_valid out 1 sample strobe.

Function
REQ-007 SHALL accept config when cfg_valid && cfg_ready, capturing all cfg_* into a shadow set; cfg_ready SHALL drop the next cycle and stay low while shadow pending.
REQ-008 SHALL commit shadow to active set on the first cycle with pending && (sample_en || !active_enable); cfg_ready SHALL rise the cycle after commit.
REQ-009 On a sample cycle (sample_en && enable, using values committed that cycle if any): stage-1 phase p = base + offset, where base = 0 if committing with phase_rst else acc; acc <= base + inc, modulo 2^PHASE_W; mode and amp SHALL travel with the sample through the pipeline.
REQ-010 With enable=0, acc, wave_out hold and no sample enters the pipeline; sample_en ignored.
REQ-011 Index q = p[PHASE_W-1 -: 2] quadrant, k = p[PHASE_W-3 -: LUT_AW].
REQ-012 SINE: T[k] = round(MAX*sin(pi/2*k/2^LUT_AW)); q0 T[k]; q1 T[~k]; q2 -T[k]; q3 -T[~k].
REQ-013 SQUARE: +MAX when q<2, else -MAX.
REQ-014 SAW: top OUT_W bits of p with MSB inverted, as signed (phase 0 -> -2^(OUT_W-1)).
REQ-015 TRIANGLE: t = top OUT_W+1 bits of p; u = t[OUT_W-1:0] if t MSB=0 else ~t[OUT_W-1:0]; result = u with MSB inverted (phase 0 -> -2^(OUT_W-1), phase 1/2 -> MAX).
REQ-016 Scaling: full-precision signed product wave*amp, arithmetic shift right 15, saturate to [-2^(OUT_W-1), MAX].
REQ-017 Latency fixed at 3 cycles: sample accepted cycle N -> wave_out updated and out_valid high for exactly one cycle at N+3; back-to-back sample_en SHALL yield back-to-back out_valid.
REQ-018 wave_out SHALL hold its last value between strobes.

Reset
REQ-019 rst_n low SHALL asynchronously clear: acc 0, active and shadow set (inc 0, offset 0, amp 0, mode SINE, enable 0), pending 0, pipeline valids 0, wave_out 0, out_valid 0; cfg_ready 1.
REQ-020 Reset mid-pipeline SHALL discard in-flight samples; no out_valid after reset release until a new sample is accepted.

Structure
REQ-021 Package wave_synth_pkg SHALL hold mode enum (SINE=0, SQUARE=1, SAW=2, TRIANGLE=3), default parameter constants and the config struct type.
REQ-022 Quarter-wave table SHALL be sub-module wave_sine_rom (registered read, one pipeline stage), parameterised by LUT_AW and OUT_W.

Verification
REQ-023 Reset, cfg SINE inc=2^30 amp=0x8000 enable=1, sample_en continuous -> wave_out sequence 0, MAX (T[~0]), 0, -MAX repeating, first strobe 3 cycles after first sample.
REQ-024 SQUARE inc=2^29 amp=0x4000 -> +16383 x4, -16384 x4 repeating (OUT_W=16).
REQ-025 SAW inc=2^31 -> -32768, 0 alternating; TRIANGLE same inc -> -32768, 32767 alternating.
REQ-026 New cfg (cfg_phase_rst=1, offset=2^30) issued mid-stream -> cfg_ready low until commit at next sample_en; that sample uses base 0 and new offset; cfg_valid held while cfg_ready low not double-accepted.
REQ-027 amp=0xFFFF, SQUARE -> saturates to +32767/-32768; enable=0 -> no out_valid, wave_out held.
REQ-028 rst_n asserted with 3 samples in flight -> outputs 0 immediately, no out_valid after release.
